// File: rtl/mem_port_arbiter_if.sv
// Shared data-memory port bundle: two manager request channels plus the memory strobe side.
// The arbiter connects through the master modport; the surrounding environment uses the slave modport.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              M0_REQ;
    logic              M0_WE;
    logic [1:0]        M0_SIZE;
    logic [ADDR_W-1:0] M0_ADDR;
    logic [DATA_W-1:0] M0_WDATA;
    logic [DATA_W-1:0] M0_RDATA;
    logic              M0_ACK;

    logic              M1_REQ;
    logic              M1_WE;
    logic [1:0]        M1_SIZE;
    logic [ADDR_W-1:0] M1_ADDR;
    logic [DATA_W-1:0] M1_WDATA;
    logic [DATA_W-1:0] M1_RDATA;
    logic              M1_ACK;

    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA_O;
    logic [DATA_W-1:0] DATA_I;
    logic              WRSTB;
    logic              RDSTB;
    logic [1:0]        SIZE;
    logic [1:0]        GNT;
    logic              BUSY;

    modport master (
        input  M0_REQ, M0_WE, M0_SIZE, M0_ADDR, M0_WDATA,
        input  M1_REQ, M1_WE, M1_SIZE, M1_ADDR, M1_WDATA,
        input  DATA_I,
        output M0_RDATA, M0_ACK, M1_RDATA, M1_ACK,
        output ADDR, DATA_O, WRSTB, RDSTB, SIZE, GNT, BUSY
    );

    modport slave (
        output M0_REQ, M0_WE, M0_SIZE, M0_ADDR, M0_WDATA,
        output M1_REQ, M1_WE, M1_SIZE, M1_ADDR, M1_WDATA,
        output DATA_I,
        input  M0_RDATA, M0_ACK, M1_RDATA, M1_ACK,
        input  ADDR, DATA_O, WRSTB, RDSTB, SIZE, GNT, BUSY
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-manager arbiter for the single data-memory strobe port: round-robin grant, fixed-latency
// strobe window, registered read data and a one-cycle ACK. Define ARB_FIXED_PRIO_EN for M0-priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                ACLK,
    input  logic                RESETn,
    mem_port_arbiter_if.master  bus
);
    localparam int unsigned     CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_o_q, data_o_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              rdstb_q, rdstb_d;
    logic              wrstb_q, wrstb_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win_m1;

    // State and output registers; last_grant resets to M1 so M0 wins the first tie
    always_ff @(posedge ACLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_o_q     <= '0;
            size_q       <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            rdstb_q      <= 1'b0;
            wrstb_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_o_q     <= data_o_d;
            size_q       <= size_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            rdstb_q      <= rdstb_d;
            wrstb_q      <= wrstb_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Next-state logic; strobes and ACKs are computed one cycle ahead so they leave straight from flops
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        data_o_d     = data_o_q;
        size_d       = size_q;
        gnt_d        = gnt_q;
        busy_d       = busy_q;
        rdstb_d      = 1'b0;
        wrstb_d      = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

`ifdef ARB_FIXED_PRIO_EN
        win_m1 = bus.M1_REQ & ~bus.M0_REQ;
`else
        win_m1 = bus.M1_REQ & (~bus.M0_REQ | ~last_grant_q);
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.M0_REQ || bus.M1_REQ) begin
                    if (win_m1) begin
                        we_d     = bus.M1_WE;
                        addr_d   = bus.M1_ADDR;
                        data_o_d = bus.M1_WDATA;
                        size_d   = bus.M1_SIZE;
                        gnt_d    = 2'b10;
                    end else begin
                        we_d     = bus.M0_WE;
                        addr_d   = bus.M0_ADDR;
                        data_o_d = bus.M0_WDATA;
                        size_d   = bus.M0_SIZE;
                        gnt_d    = 2'b01;
                    end
                    last_grant_d = win_m1;
                    cnt_d        = CNT_LOAD;
                    busy_d       = 1'b1;
                    rdstb_d      = ~we_d;
                    wrstb_d      = we_d;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                    rdstb_d = ~we_q;
                    wrstb_d = we_q;
                end else begin
                    // Last strobe cycle: memory data is valid now
                    if (!we_q) begin
                        if (gnt_q[1]) rdata1_d = bus.DATA_I;
                        else          rdata0_d = bus.DATA_I;
                    end
                    ack0_d  = gnt_q[0];
                    ack1_d  = gnt_q[1];
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ADDR     = addr_q;
    assign bus.DATA_O   = data_o_q;
    assign bus.SIZE     = size_q;
    assign bus.RDSTB    = rdstb_q;
    assign bus.WRSTB    = wrstb_q;
    assign bus.GNT      = gnt_q;
    assign bus.BUSY     = busy_q;
    assign bus.M0_ACK   = ack0_q;
    assign bus.M1_ACK   = ack1_q;
    assign bus.M0_RDATA = rdata0_q;
    assign bus.M1_RDATA = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter at MEM_LAT 2, plus latency corners at 1 and 15.
// Expected values follow the cycle-by-cycle arbitration behaviour; ARB_FIXED_PRIO_EN alters test 3 only.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic        req;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
    } mreq_t;

    // ctl = {RDSTB, WRSTB, GNT[1], GNT[0], BUSY, M1_ACK, M0_ACK}
    typedef struct {
        mreq_t       m0;
        mreq_t       m1;
        logic [31:0] di;
        logic [6:0]  ctl;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_RD0  = 7'b1001100;
    localparam logic [6:0] C_RD1  = 7'b1010100;
    localparam logic [6:0] C_WR0  = 7'b0101100;
    localparam logic [6:0] C_WR1  = 7'b0110100;
    localparam logic [6:0] C_ACK0 = 7'b0001101;
    localparam logic [6:0] C_ACK1 = 7'b0010110;

    localparam mreq_t NOP     = '0;
    localparam mreq_t A_RD100 = '{req: 1'b1, we: 1'b0, sz: 2'd2, a: 32'h0000_0100, wd: 32'h0};
    localparam mreq_t B_WR40  = '{req: 1'b1, we: 1'b1, sz: 2'd2, a: 32'h0000_0040, wd: 32'h1234_5678};
    localparam mreq_t A_RD200 = '{req: 1'b1, we: 1'b0, sz: 2'd2, a: 32'h0000_0200, wd: 32'h0};
    localparam mreq_t B_RD300 = '{req: 1'b1, we: 1'b0, sz: 2'd2, a: 32'h0000_0300, wd: 32'h0};
    localparam mreq_t A_WR500 = '{req: 1'b1, we: 1'b1, sz: 2'd1, a: 32'h0000_0500, wd: 32'h55AA_55AA};
    localparam mreq_t B_RD600 = '{req: 1'b1, we: 1'b0, sz: 2'd0, a: 32'h0000_0600, wd: 32'h0};
    localparam mreq_t A_RD900 = '{req: 1'b1, we: 1'b0, sz: 2'd2, a: 32'h0000_0900, wd: 32'h0};
    localparam mreq_t B_RD700 = '{req: 1'b1, we: 1'b0, sz: 2'd1, a: 32'h0000_0700, wd: 32'h0};

    logic ACLK = 1'b0;
    logic RESETn;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];
    vec_t tbl5[$];

    always #5 ACLK = ~ACLK;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if2  ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1  ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if15 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2))  u_lat2  (.ACLK(ACLK), .RESETn(RESETn), .bus(if2.master));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1))  u_lat1  (.ACLK(ACLK), .RESETn(RESETn), .bus(if1.master));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15)) u_lat15 (.ACLK(ACLK), .RESETn(RESETn), .bus(if15.master));

    function automatic vec_t mk(input mreq_t m0, input mreq_t m1, input logic [31:0] di,
                                input logic [6:0] ctl, input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.m0  = m0;
        v.m1  = m1;
        v.di  = di;
        v.ctl = ctl;
        v.rd0 = rd0;
        v.rd1 = rd1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl2();
        return {if2.RDSTB, if2.WRSTB, if2.GNT, if2.BUSY, if2.M1_ACK, if2.M0_ACK};
    endfunction

    task automatic drive2(input mreq_t m0, input mreq_t m1, input logic [31:0] di);
        if2.M0_REQ = m0.req; if2.M0_WE = m0.we; if2.M0_SIZE = m0.sz; if2.M0_ADDR = m0.a; if2.M0_WDATA = m0.wd;
        if2.M1_REQ = m1.req; if2.M1_WE = m1.we; if2.M1_SIZE = m1.sz; if2.M1_ADDR = m1.a; if2.M1_WDATA = m1.wd;
        if2.DATA_I = di;
    endtask

    // One cycle: drive just after the rising edge, compare at the falling edge
    task automatic run_row(input vec_t v, input string tag);
        mreq_t own;
        @(posedge ACLK);
        #1;
        drive2(v.m0, v.m1, v.di);
        @(negedge ACLK);
        check({tag, " ctl"}, 32'(ctl2()), 32'(v.ctl));
        check({tag, " m0_rdata"}, if2.M0_RDATA, v.rd0);
        check({tag, " m1_rdata"}, if2.M1_RDATA, v.rd1);
        if (v.ctl[6] || v.ctl[5]) begin
            own = v.ctl[4] ? v.m1 : v.m0;
            check({tag, " addr"}, if2.ADDR, own.a);
            check({tag, " data_o"}, if2.DATA_O, own.wd);
            check({tag, " size"}, 32'(if2.SIZE), 32'(own.sz));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e0, e1, di;
        logic [31:0] pat [4];
        logic        owner, last;
        int          n1, n15, a1, a15, k1, k15;

        RESETn = 1'b0;
        drive2(NOP, NOP, 32'h0);
        if1.M0_REQ = 1'b0; if1.M0_WE = 1'b0; if1.M0_SIZE = 2'd0; if1.M0_ADDR = '0; if1.M0_WDATA = '0;
        if1.M1_REQ = 1'b0; if1.M1_WE = 1'b0; if1.M1_SIZE = 2'd0; if1.M1_ADDR = '0; if1.M1_WDATA = '0;
        if1.DATA_I = '0;
        if15.M0_REQ = 1'b0; if15.M0_WE = 1'b0; if15.M0_SIZE = 2'd0; if15.M0_ADDR = '0; if15.M0_WDATA = '0;
        if15.M1_REQ = 1'b0; if15.M1_WE = 1'b0; if15.M1_SIZE = 2'd0; if15.M1_ADDR = '0; if15.M1_WDATA = '0;
        if15.DATA_I = '0;

        // Build the main table with a running read-data model
        e0 = '0; e1 = '0;
        tbl.push_back(mk(A_RD100, NOP, 32'h0, C_IDLE, e0, e1));
        tbl.push_back(mk(A_RD100, NOP, 32'h0, C_RD0, e0, e1));
        tbl.push_back(mk(A_RD100, NOP, 32'hDEAD_BEEF, C_RD0, e0, e1));
        e0 = 32'hDEAD_BEEF;
        tbl.push_back(mk(NOP, NOP, 32'h0, C_ACK0, e0, e1));
        tbl.push_back(mk(NOP, B_WR40, 32'h0, C_IDLE, e0, e1));
        tbl.push_back(mk(NOP, B_WR40, 32'h0, C_WR1, e0, e1));
        tbl.push_back(mk(NOP, B_WR40, 32'h0, C_WR1, e0, e1));
        tbl.push_back(mk(NOP, NOP, 32'h0, C_ACK1, e0, e1));

        pat[0] = 32'hA0A0_A0A0; pat[1] = 32'hB1B1_B1B1; pat[2] = 32'hC2C2_C2C2; pat[3] = 32'hD3D3_D3D3;
        for (int k = 0; k < 4; k++) begin
            owner = FIXED ? 1'b0 : k[0];
            last  = (k == 3);
            di    = pat[k];
            tbl.push_back(mk(A_RD200, B_RD300, 32'h0, C_IDLE, e0, e1));
            tbl.push_back(mk(A_RD200, B_RD300, 32'h0, owner ? C_RD1 : C_RD0, e0, e1));
            tbl.push_back(mk(A_RD200, B_RD300, di, owner ? C_RD1 : C_RD0, e0, e1));
            if (owner) e1 = di; else e0 = di;
            tbl.push_back(mk(last ? NOP : A_RD200, last ? NOP : B_RD300, 32'h0, owner ? C_ACK1 : C_ACK0, e0, e1));
        end

        tbl.push_back(mk(A_WR500, NOP, 32'h0, C_IDLE, e0, e1));
        tbl.push_back(mk(A_WR500, B_RD600, 32'h0, C_WR0, e0, e1));
        tbl.push_back(mk(A_WR500, B_RD600, 32'h0, C_WR0, e0, e1));
        tbl.push_back(mk(NOP, B_RD600, 32'h0, C_ACK0, e0, e1));
        tbl.push_back(mk(NOP, B_RD600, 32'h0, C_IDLE, e0, e1));
        tbl.push_back(mk(NOP, B_RD600, 32'h0, C_RD1, e0, e1));
        tbl.push_back(mk(NOP, B_RD600, 32'h600D_F00D, C_RD1, e0, e1));
        e1 = 32'h600D_F00D;
        tbl.push_back(mk(NOP, NOP, 32'h0, C_ACK1, e0, e1));
        tbl.push_back(mk(NOP, NOP, 32'h0, C_IDLE, e0, e1));

        // Reset values
        repeat (3) @(negedge ACLK);
        check("reset ctl", 32'(ctl2()), 32'h0);
        check("reset addr", if2.ADDR, 32'h0);
        check("reset data_o", if2.DATA_O, 32'h0);
        check("reset size", 32'(if2.SIZE), 32'h0);
        check("reset m0_rdata", if2.M0_RDATA, 32'h0);
        check("reset m1_rdata", if2.M1_RDATA, 32'h0);
        RESETn = 1'b1;

        for (int i = 0; i < int'(tbl.size()); i++)
            run_row(tbl[i], $sformatf("main_c%0d", i));

        // Latency corners at MEM_LAT 1 and 15, started in the same cycle
        @(posedge ACLK);
        #1;
        if1.M0_REQ = 1'b1;  if1.M0_ADDR = 32'h80;  if1.DATA_I = 32'h1111_1111;
        if15.M0_REQ = 1'b1; if15.M0_ADDR = 32'h84; if15.DATA_I = 32'hF15F_15F1;
        n1 = 0; n15 = 0; a1 = -1; a15 = -1; k1 = 0; k15 = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge ACLK);
            if (if1.RDSTB)  n1++;
            if (if15.RDSTB) n15++;
            if (if1.M0_ACK) begin
                k1++;
                if (a1 < 0) a1 = c;
                if1.M0_REQ = 1'b0;
            end
            if (if15.M0_ACK) begin
                k15++;
                if (a15 < 0) a15 = c;
                if15.M0_REQ = 1'b0;
            end
        end
        check("lat1 strobe cycles", 32'(n1), 32'd1);
        check("lat1 ack cycle", 32'(a1), 32'd2);
        check("lat1 ack count", 32'(k1), 32'd1);
        check("lat1 rdata", if1.M0_RDATA, 32'h1111_1111);
        check("lat15 strobe cycles", 32'(n15), 32'd15);
        check("lat15 ack cycle", 32'(a15), 32'd16);
        check("lat15 ack count", 32'(k15), 32'd1);
        check("lat15 rdata", if15.M0_RDATA, 32'hF15F_15F1);

        // Reset in the middle of an M0 read
        run_row(mk(A_RD900, NOP, 32'h0, C_IDLE, e0, e1), "rst_c0");
        run_row(mk(A_RD900, NOP, 32'hBAD0_BAD0, C_RD0, e0, e1), "rst_c1");
        #2;
        RESETn = 1'b0;
        #1;
        check("rst async ctl", 32'(ctl2()), 32'h0);
        check("rst async addr", if2.ADDR, 32'h0);
        check("rst async m0_rdata", if2.M0_RDATA, 32'h0);
        check("rst async m1_rdata", if2.M1_RDATA, 32'h0);
        drive2(NOP, NOP, 32'hBAD0_BAD0);
        repeat (2) @(negedge ACLK);
        RESETn = 1'b1;

        for (int i = 0; i < 3; i++)
            tbl5.push_back(mk(NOP, NOP, 32'hBAD0_BAD0, C_IDLE, 32'h0, 32'h0));
        tbl5.push_back(mk(NOP, B_RD700, 32'h0, C_IDLE, 32'h0, 32'h0));
        tbl5.push_back(mk(NOP, B_RD700, 32'h0, C_RD1, 32'h0, 32'h0));
        tbl5.push_back(mk(NOP, B_RD700, 32'h7777_AAAA, C_RD1, 32'h0, 32'h0));
        tbl5.push_back(mk(NOP, NOP, 32'h0, C_ACK1, 32'h0, 32'h7777_AAAA));
        tbl5.push_back(mk(NOP, NOP, 32'h0, C_IDLE, 32'h0, 32'h7777_AAAA));
        for (int i = 0; i < int'(tbl5.size()); i++)
            run_row(tbl5[i], $sformatf("post_rst_c%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single data-memory strobe port (ADDR / DATA_O / DATA_I / WRSTB / RDSTB) between two managers:
- M0: CPU stage-4 load/store.
- M1: DMA/debug loader that fills memory while the core runs or sits in reset.

The block arbitrates round-robin, latches the winning request, holds the memory strobes for a fixed access latency, captures read data and returns a one-cycle ACK to the owner.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles per transfer (strobe high time); legal 1..15

Ports:
ACLK  in  1  global clock, rising edge
RESETn  in  1  asynchronous reset, active low
Mx_REQ (x=0,1)  in  1  request, level; held until Mx_ACK seen
Mx_WE  in  1  1=write, 0=read; valid while Mx_REQ
Mx_SIZE  in  2  0=byte, 1=half, 2=word; passed through
Mx_ADDR  in  ADDR_W  request address
Mx_WDATA  in  DATA_W  write data
Mx_RDATA  out  DATA_W  read data; registered, valid from ACK cycle, held until next read ACK to Mx
Mx_ACK  out  1  one-cycle completion pulse
ADDR  out  ADDR_W  memory address
DATA_O  out  DATA_W  memory write data
DATA_I  in  DATA_W  memory read data, valid in last ACCESS cycle
WRSTB / RDSTB  out  1  memory write / read strobe
SIZE  out  2  latched size to memory
GNT  out  2  one-hot current owner (bit0=M0); 00 when idle
BUSY  out  1  1 in ACCESS or RESP

Behaviour:
- Reset (RESETn low, async, any state):
  - All outputs 0: strobes, ACKs, GNT, BUSY, ADDR, DATA_O, SIZE, M0_RDATA, M1_RDATA.
  - State=IDLE, cnt=0, last_grant=1 (M0 wins the first tie).
  - In-flight transfer is abandoned; no ACK after release.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay IDLE.
  - Exactly one REQ high: grant it.
  - Both high: grant the manager not equal to last_grant.
  - On grant:
    - Latch that manager's ADDR/WDATA/WE/SIZE into ADDR/DATA_O/SIZE/we_q.
    - Set GNT; last_grant<=winner; cnt<=MEM_LAT-1.
    - Next state ACCESS.
- ACCESS:
  - RDSTB=~we_q and WRSTB=we_q, both for the whole state; ADDR/DATA_O/SIZE stable.
  - cnt!=0: cnt<=cnt-1, stay.
  - cnt==0 (last cycle): if read, capture DATA_I into owner's RDATA; next state RESP.
  - Strobes are high for exactly MEM_LAT cycles.
- RESP:
  - Strobes low.
  - Owner's ACK=1 for exactly this cycle; the other ACK stays 0.
  - Next state IDLE; GNT<=00.
- Latency: REQ first high in cycle 0 with the port idle gives strobes in cycles 1..MEM_LAT and ACK in cycle MEM_LAT+1. Minimum spacing of back-to-back grants is MEM_LAT+2 cycles.
- Requester contract: deassert REQ (or present a new request) at the edge that samples ACK=1. Because the arbiter is in RESP during ACK, a held REQ never double-issues.
- Request inputs are ignored outside IDLE. A REQ that rises or falls during another's transfer is arbitrated only at the next IDLE.
- Writes leave RDATA unchanged. ADDR/DATA_O/SIZE hold their last values in IDLE; only strobes qualify them.
- Fairness: with both REQ permanently high, grants alternate M0, M1, M0, … Neither manager waits more than one full transfer.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
Macro ARB_FIXED_PRIO_EN.
- Defined: M0 always wins ties and last_grant is unused. M1 is served only when M0_REQ is low in IDLE.
- Undefined: round-robin as specified above.

Test Plan:
1. Reset, MEM_LAT=2; M0 read ADDR=0x100, DATA_I=0xDEADBEEF in cycle 2 -> RDSTB high cycles 1–2, M0_ACK cycle 3, M0_RDATA=0xDEADBEEF, GNT=01 cycles 1–3 then 00.
2. M1 write ADDR=0x40, WDATA=0x12345678, SIZE=2 -> WRSTB high 2 cycles, DATA_O=0x12345678, SIZE=2, M1_ACK once, M1_RDATA unchanged.
3. M0 and M1 requesting continuously from reset -> grant order M0, M1, M0, M1; each ACK every 8 cycles (4 cycles/transfer); no cycle with both ACKs high. With ARB_FIXED_PRIO_EN defined -> only M0 granted.
4. MEM_LAT=1 and MEM_LAT=15 -> strobe high exactly 1 / 15 cycles; ACK at cycle 2 / 16 after request.
5. Assert RESETn low in the middle of an ACCESS read -> strobes, GNT, BUSY drop immediately; no ACK after release; next M1 request is granted normally.
6. M1_REQ rises while M0 is in ACCESS -> M1 is granted in the IDLE cycle after M0_ACK; M0 request data is not disturbed.
